// File: rtl/ezm_prog_feeder_if.sv
// Bus between the program feeder and its host/core side.
// Optional trace signals exist only when EZM_FEEDER_TRACE_EN is defined.
interface ezm_prog_feeder_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          load_i;
  logic          wr_valid_i;
  logic [5:0]    wr_data_i;
  logic          run_i;
  logic [7:0]    cpu_out_i;
  logic [5:0]    instr_o;
  logic          cpu_rst_o;
  logic          phase_o;
  logic          halt_o;
  logic          full_o;
  logic [AW:0]   prog_len_o;
`ifdef EZM_FEEDER_TRACE_EN
  logic [7:0]    acc_o;
  logic          acc_valid_o;
`endif

`ifdef EZM_FEEDER_TRACE_EN
  modport master (
    output load_i, wr_valid_i, wr_data_i, run_i, cpu_out_i,
    input  instr_o, cpu_rst_o, phase_o, halt_o, full_o, prog_len_o,
    input  acc_o, acc_valid_o
  );

  modport slave (
    input  load_i, wr_valid_i, wr_data_i, run_i, cpu_out_i,
    output instr_o, cpu_rst_o, phase_o, halt_o, full_o, prog_len_o,
    output acc_o, acc_valid_o
  );
`else
  modport master (
    output load_i, wr_valid_i, wr_data_i, run_i, cpu_out_i,
    input  instr_o, cpu_rst_o, phase_o, halt_o, full_o, prog_len_o
  );

  modport slave (
    input  load_i, wr_valid_i, wr_data_i, run_i, cpu_out_i,
    output instr_o, cpu_rst_o, phase_o, halt_o, full_o, prog_len_o
  );
`endif
endinterface

// File: rtl/ezm_prog_feeder.sv
// Program store and instruction feeder for the accumulator core.
// Define EZM_FEEDER_TRACE_EN to add the accumulator trace outputs.
module ezm_prog_feeder #(
  parameter int DEPTH = 16
) (
  input logic              clk,
  input logic              rst,
  ezm_prog_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_e;

  state_e      state_q, state_d;
  logic [AW:0] wp_q, wp_d;
  logic [AW:0] prog_len_q, prog_len_d;
  logic [5:0]  hold_q, hold_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        phase_q, phase_d;
  logic        halt_q, halt_d;
  logic        mem_we;
  logic        fetch_ok;
  logic [5:0]  fetch_word;
  logic [5:0]  mem [DEPTH];

  // Full 8-bit pc is compared so a wrapped pc (e.g. 0xFF) never aliases into the store.
  assign fetch_ok   = {1'b0, bus.cpu_out_i} < 9'(prog_len_q);
  assign fetch_word = fetch_ok ? mem[bus.cpu_out_i[AW-1:0]] : 6'b000000;

  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    prog_len_d = prog_len_q;
    hold_d     = hold_q;
    phase_d    = 1'b0;
    mem_we     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.load_i) begin
          state_d = S_LOAD;
          wp_d    = '0;
        end else if (bus.run_i && (prog_len_q != '0)) begin
          state_d = S_RUN;
        end
      end
      S_LOAD: begin
        if (bus.wr_valid_i && (wp_q < FULL_CNT)) begin
          mem_we = 1'b1;
          wp_d   = wp_q + 1'b1;
        end
        if (!bus.load_i) begin
          state_d    = S_IDLE;
          prog_len_d = wp_d;
        end
      end
      S_RUN: begin
        if (!phase_q) hold_d = fetch_word;
        if (bus.load_i) begin
          state_d = S_IDLE;
        end else if (!phase_q && !fetch_ok) begin
          state_d = S_HALT;
        end else begin
          phase_d = ~phase_q;
        end
      end
      S_HALT: begin
        if (bus.load_i) begin
          state_d = S_LOAD;
          wp_d    = '0;
        end else if (bus.run_i) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Core reset tracks the next state so the core always restarts in fetch with phase 0.
    cpu_rst_d = (state_d != S_RUN);
    halt_d    = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wp_q       <= '0;
      prog_len_q <= '0;
      hold_q     <= 6'b000000;
      cpu_rst_q  <= 1'b1;
      phase_q    <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      prog_len_q <= prog_len_d;
      hold_q     <= hold_d;
      cpu_rst_q  <= cpu_rst_d;
      phase_q    <= phase_d;
      halt_q     <= halt_d;
    end
  end

  // Program store has no reset; prog_len of zero makes stale words unreachable.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[wp_q[AW-1:0]] <= bus.wr_data_i;
  end

  assign bus.instr_o    = (state_q == S_RUN) ? (phase_q ? hold_q : fetch_word) : 6'b000000;
  assign bus.cpu_rst_o  = cpu_rst_q;
  assign bus.phase_o    = phase_q;
  assign bus.halt_o     = halt_q;
  assign bus.full_o     = (wp_q == FULL_CNT);
  assign bus.prog_len_o = prog_len_q;

`ifdef EZM_FEEDER_TRACE_EN
  logic [7:0] acc_q, acc_d;
  logic       acc_valid_q, acc_valid_d;

  always_comb begin
    acc_d       = acc_q;
    acc_valid_d = 1'b0;
    if ((state_q == S_RUN) && phase_q) begin
      acc_d       = bus.cpu_out_i;
      acc_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= 8'h00;
      acc_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      acc_valid_q <= acc_valid_d;
    end
  end

  assign bus.acc_o       = acc_q;
  assign bus.acc_valid_o = acc_valid_q;
`endif
endmodule

// File: tb/tb_ezm_prog_feeder.sv
// Bench for ezm_prog_feeder: the bench plays the host and the core, and checks
// every cycle against a behavioural model plus literal expectations.
module tb_ezm_prog_feeder;
  localparam int DEPTH = 16;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;
  localparam int M_HALT = 3;

  typedef struct {
    int mode;
    int wp;
    int len;
    int hold;
    int phase;
    int acc;
    int acc_valid;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   check_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  model_t m = '{default: 0};
  int     m_mem [DEPTH];

  ezm_prog_feeder_if #(.DEPTH(DEPTH)) bus_if ();

  ezm_prog_feeder #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 1 time unit after the edge; callers check outputs 2 units later.
  task automatic applyStimulus(input bit r, input bit ld, input bit wr, input logic [5:0] d,
                               input bit rn, input logic [7:0] co);
    @(posedge clk);
    #1;
    rst               = r;
    bus_if.load_i     = ld;
    bus_if.wr_valid_i = wr;
    bus_if.wr_data_i  = d;
    bus_if.run_i      = rn;
    bus_if.cpu_out_i  = co;
    #2;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h00);
  endtask

  task automatic loadProgram(input int n, input logic [5:0] words [8]);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 8'h00);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b1, words[i], 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h00);
  endtask

  function automatic int fetchWord(input int pc, input int len);
    return (pc < len) ? m_mem[pc % DEPTH] : 0;
  endfunction

  function automatic model_t modelNext(input model_t cur, input bit r, input bit ld, input bit wr,
                                       input bit rn, input int co);
    model_t n = cur;
    n.acc_valid = 0;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    if (cur.mode == M_RUN && cur.phase == 1) begin
      n.acc       = co;
      n.acc_valid = 1;
    end
    case (cur.mode)
      M_IDLE: begin
        if (ld) begin n.mode = M_LOAD; n.wp = 0; end
        else if (rn && cur.len > 0) begin n.mode = M_RUN; n.phase = 0; end
      end
      M_LOAD: begin
        if (wr && cur.wp < DEPTH) n.wp = cur.wp + 1;
        if (!ld) begin n.mode = M_IDLE; n.len = n.wp; end
      end
      M_RUN: begin
        if (cur.phase == 0) n.hold = fetchWord(co, cur.len);
        if (ld) begin n.mode = M_IDLE; n.phase = 0; end
        else if (cur.phase == 0 && co >= cur.len) begin n.mode = M_HALT; n.phase = 0; end
        else n.phase = 1 - cur.phase;
      end
      default: begin
        if (ld) begin n.mode = M_LOAD; n.wp = 0; end
        else if (rn) begin n.mode = M_RUN; n.phase = 0; end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    if (!rst && m.mode == M_LOAD && bus_if.wr_valid_i && m.wp < DEPTH)
      m_mem[m.wp] <= int'(bus_if.wr_data_i);
    m <= modelNext(m, rst, bus_if.load_i, bus_if.wr_valid_i, bus_if.run_i, int'(bus_if.cpu_out_i));
  end

  always @(negedge clk) begin
    if (check_en) begin
      int exp_instr;
      exp_instr = (m.mode != M_RUN) ? 0 :
                  (m.phase == 0) ? fetchWord(int'(bus_if.cpu_out_i), m.len) : m.hold;
      checkOutput("instr_o",    32'(bus_if.instr_o),    32'(exp_instr));
      checkOutput("cpu_rst_o",  32'(bus_if.cpu_rst_o),  32'(m.mode != M_RUN));
      checkOutput("phase_o",    32'(bus_if.phase_o),    32'(m.phase));
      checkOutput("halt_o",     32'(bus_if.halt_o),     32'(m.mode == M_HALT));
      checkOutput("full_o",     32'(bus_if.full_o),     32'(m.wp == DEPTH));
      checkOutput("prog_len_o", 32'(bus_if.prog_len_o), 32'(m.len));
`ifdef EZM_FEEDER_TRACE_EN
      checkOutput("acc_o",       32'(bus_if.acc_o),       32'(m.acc));
      checkOutput("acc_valid_o", 32'(bus_if.acc_valid_o), 32'(m.acc_valid));
`endif
    end
  end

  initial begin
    logic [5:0] prog [8];
    logic [5:0] exp_seq [7];
    logic [7:0] co_seq [7];

    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    bus_if.load_i     = 1'b0;
    bus_if.wr_valid_i = 1'b0;
    bus_if.wr_data_i  = 6'h00;
    bus_if.run_i      = 1'b0;
    bus_if.cpu_out_i  = 8'h00;

    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 8'h00);
    check_en = 1'b1;
    checkOutput("reset cpu_rst", 32'(bus_if.cpu_rst_o), 32'd1);
    checkOutput("reset prog_len", 32'(bus_if.prog_len_o), 32'd0);
    checkOutput("reset instr", 32'(bus_if.instr_o), 32'd0);

    $display("[TB] three-word program");
    prog = '{6'h25, 6'h08, 6'h01, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    loadProgram(3, prog);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 8'h00);
    checkOutput("len after load", 32'(bus_if.prog_len_o), 32'd3);
    exp_seq = '{6'h25, 6'h25, 6'h08, 6'h08, 6'h01, 6'h01, 6'h00};
    co_seq  = '{8'h00, 8'h10, 8'h01, 8'h11, 8'h02, 8'h12, 8'h03};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, co_seq[i]);
      checkOutput("run instr seq", 32'(bus_if.instr_o), 32'(exp_seq[i]));
      checkOutput("run cpu_rst low", 32'(bus_if.cpu_rst_o), 32'd0);
    end
    idleCycle();
    checkOutput("halt after pc=3", 32'(bus_if.halt_o), 32'd1);
    checkOutput("cpu_rst after halt", 32'(bus_if.cpu_rst_o), 32'd1);

    $display("[TB] overfill");
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 6'(6'h20 + i), 1'b0, 8'h00);
      if (i == 15) checkOutput("full before 16th", 32'(bus_if.full_o), 32'd0);
      if (i == 16) checkOutput("full after 16th", 32'(bus_if.full_o), 32'd1);
    end
    idleCycle();
    idleCycle();
    checkOutput("len when full", 32'(bus_if.prog_len_o), 32'd16);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h0F);
    checkOutput("last word", 32'(bus_if.instr_o), 32'h2F);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h10);
    checkOutput("pc=16 nop", 32'(bus_if.instr_o), 32'd0);
    idleCycle();
    checkOutput("halt pc=16", 32'(bus_if.halt_o), 32'd1);

    $display("[TB] run with empty program, then run+load");
    applyStimulus(1'b1, 1'b0, 1'b0, 6'h00, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 8'h00);
    idleCycle();
    checkOutput("empty run ignored", 32'(bus_if.cpu_rst_o), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 6'h11, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h00);
    idleCycle();
    checkOutput("load wins over run", 32'(bus_if.prog_len_o), 32'd1);

    $display("[TB] wrapped backward branch");
    prog = '{6'h31, 6'h32, 6'h33, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    loadProgram(3, prog);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h00);
    checkOutput("branch prog pc0", 32'(bus_if.instr_o), 32'h31);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h40);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h01);
    checkOutput("branch prog pc1", 32'(bus_if.instr_o), 32'h32);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h41);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'hFF);
    checkOutput("pc=FF nop", 32'(bus_if.instr_o), 32'd0);
    idleCycle();
    checkOutput("pc=FF halt", 32'(bus_if.halt_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h00);
    checkOutput("restart mem0", 32'(bus_if.instr_o), 32'h31);
    checkOutput("restart cpu_rst", 32'(bus_if.cpu_rst_o), 32'd0);

    $display("[TB] load mid-run, reset mid-load");
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 8'h22);
    applyStimulus(1'b0, 1'b1, 1'b0, 6'h00, 1'b0, 8'h00);
    checkOutput("abort cpu_rst", 32'(bus_if.cpu_rst_o), 32'd1);
    checkOutput("abort keeps len", 32'(bus_if.prog_len_o), 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 6'h05, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 6'h06, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 6'h00, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h00);
    checkOutput("len after rst", 32'(bus_if.prog_len_o), 32'd0);
    prog = '{6'h07, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    loadProgram(1, prog);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 8'h00);
    checkOutput("wp restarted", 32'(bus_if.prog_len_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h00);
    checkOutput("reloaded word", 32'(bus_if.instr_o), 32'h07);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h01);
    idleCycle();

`ifdef EZM_FEEDER_TRACE_EN
    $display("[TB] accumulator trace");
    prog = '{6'h3D, 6'h3D, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    loadProgram(2, prog);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'hFD);
    checkOutput("acc_valid idle in ph1", 32'(bus_if.acc_valid_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h01);
    checkOutput("acc value", 32'(bus_if.acc_o), 32'hFD);
    checkOutput("acc_valid pulse", 32'(bus_if.acc_valid_o), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'hFD);
    checkOutput("acc_valid drop", 32'(bus_if.acc_valid_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'h00, 1'b0, 8'h02);
    checkOutput("acc_valid second", 32'(bus_if.acc_valid_o), 32'd1);
    idleCycle();
    idleCycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ezm_prog_feeder.md
# ezm_prog_feeder

Program store and instruction feeder that sits directly upstream of the accumulator CPU core. It accepts a program written one 6-bit word per cycle, holds the CPU in reset while loading, then releases it and drives the instruction input. It follows the core's two-phase fetch/execute rhythm and snoops the core's multiplexed `pc`/accumulator output to select words. It halts the core when `pc` leaves the loaded program.

## Interface
- `DEPTH`, 16: program words stored (power of two, ≤256); `AW = log2(DEPTH)`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `load_i` in 1: level; request load mode.
- `wr_valid_i` in 1: write strobe for `wr_data_i` in LOAD.
- `wr_data_i` in 6: program word.
- `run_i` in 1: pulse; start execution from `pc` = 0.
- `cpu_out_i` in 8: core output; `pc` in phase 0, accumulator in phase 1.
- `instr_o` out 6: core instruction input.
- `cpu_rst_o` out 1: core reset, registered.
- `phase_o` out 1: 0 = fetch, 1 = execute.
- `halt_o` out 1: registered; set in HALT.
- `full_o` out 1: write pointer == `DEPTH`.
- `prog_len_o` out AW+1: loaded word count.

## Operation
States and transitions:
- IDLE
  - `load_i` → LOAD; clears `wp`.
  - else `run_i` with `prog_len` > 0 → RUN.
  - `run_i` with `prog_len` = 0 is ignored.
  - `load_i` wins over a simultaneous `run_i`.
- LOAD
  - Each cycle with `wr_valid_i` and `wp` < `DEPTH`: `mem[wp]` ← `wr_data_i`, `wp`++.
  - Writes while full are dropped silently.
  - `load_i` = 0 → IDLE; `prog_len` ← `wp` on the same edge.
- RUN
  - `phase` toggles every cycle, starting at 0 on the first RUN cycle.
  - `load_i` = 1 → IDLE; `cpu_rst_o` ← 1 and `prog_len` is kept.
- HALT
  - `run_i` → RUN (restart at `pc` = 0).
  - `load_i` → LOAD; `load_i` has priority.
- `cpu_rst_o` = 1 in every state except RUN. This keeps the core in fetch state, so core state and `phase` stay aligned.

Instruction path in RUN:
- Phase 0: `instr_o` = `mem[cpu_out_i[AW-1:0]]` combinationally when all 8 bits of `cpu_out_i` < `prog_len`; otherwise `6'b000000` (NOP). The word is latched into `hold` at the end of phase 0.
- Phase 1: `instr_o` = `hold`. The core reads its operand field in phase 1, so the word is stable across both phases.
- Phase 0 with `cpu_out_i` ≥ `prog_len`: NOP is presented, the state goes to HALT at that edge, and `cpu_rst_o` ← 1.
- The full 8-bit `pc` is compared. A backward branch that wraps `pc` (e.g. to 255) therefore halts.
- Outside RUN, `instr_o` = 0.
- Memory contents are not reset; `prog_len` = 0 makes them unreachable.

## Timing
Reset values (edge with `rst` = 1):
- State IDLE, `wp` = 0, `prog_len_o` = 0, `hold` = 0.
- `instr_o` = 0, `cpu_rst_o` = 1, `phase_o` = 0, `halt_o` = 0, `full_o` = 0.
- `rst` mid-LOAD discards the partial load. `rst` mid-RUN stops the core next cycle via `cpu_rst_o`.

Latencies:
- `run_i` sampled at edge N: RUN, `cpu_rst_o` = 0, and `phase` = 0 from cycle N+1. The core's first fetch is in cycle N+1 with `pc` = 0.
- Fetch read latency is zero (combinational from `cpu_out_i`). The core registers the result.
- HALT detect: `halt_o` and `cpu_rst_o` rise one cycle after the offending fetch phase. The core executes at most one NOP phase before that.
- `full_o` updates on the same edge as the write that fills the last slot.
- `prog_len_o` updates on the LOAD → IDLE edge only.

## Configuration
- `EZM_FEEDER_TRACE_EN` defined:
  - Adds outputs `acc_o[7:0]` and `acc_valid_o`.
  - In each RUN phase 1, `acc_o` ← `cpu_out_i` on the closing edge, and `acc_valid_o` pulses for one cycle after that edge.
  - Reset: `acc_o` = 0, `acc_valid_o` = 0.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

## Test plan
- Load 3 words (`0x25`, `0x08`, `0x01`), drop `load_i`, pulse `run_i`:
  - `prog_len_o` = 3.
  - `instr_o` = `0x25` for 2 cycles, then `0x08` for 2 cycles, then `0x01` for 2 cycles.
  - NOP at `pc` = 3, then `halt_o` = 1 and `cpu_rst_o` = 1.
- Write 20 words with `DEPTH` = 16: `full_o` = 1 after the 16th write, writes 17–20 are dropped, `prog_len_o` = 16.
- Assert `run_i` with `prog_len` = 0, then `run_i` and `load_i` together in IDLE: the first is ignored (`cpu_rst_o` stays 1); the second enters LOAD.
- Backward branch taken to `pc` = `0xFF`: NOP is presented and HALT is entered. A subsequent `run_i` restarts with `instr_o` = `mem[0]`.
- `load_i` mid-RUN and `rst` mid-LOAD: the first gives IDLE with `cpu_rst_o` = 1; the second gives `prog_len_o` = 0 and `wp` = 0.
- With `EZM_FEEDER_TRACE_EN`, run a program loading `-3` (`0x3D`): `acc_o` = `0xFD` with `acc_valid_o` pulsing once per instruction.
